count_checker: RTL

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_checker.sv | 113 +++++++++++
 1 files changed

// File: rtl/count_checker.sv
// Scoreboard for a loadable up-counter: shadows the observed count until
// armed, then predicts and compares it every edge, latching into FAIL on MAX_ERR errors.
module count_checker #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_ERR = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] obs_count,
    input  logic             check_en,
    output logic             mismatch,
    output logic [7:0]       err_count,
    output logic [15:0]      checks,
    output logic             wrap,
    output logic             locked,
    output logic             fail
);

    typedef enum logic [1:0] {
        SHADOW,
        TRACK,
        FAIL
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   exp, exp_nxt;
    logic [7:0]         err_nxt;
    logic [15:0]        checks_nxt;
    logic               mismatch_nxt;
    logic               wrap_nxt;
    logic               compare;
    logic               miss;
    logic [WIDTH-1:0]   pred;

    // On a match exp equals obs_count, so advancing from obs_count covers
    // both the match and the resync-after-mismatch cases.
    always_comb begin
        pred = obs_count;
        if (load)
            pred = load_value;
        else if (enable)
            pred = obs_count + WIDTH'(1);
    end

    always_comb begin
        state_nxt    = state;
        exp_nxt      = exp;
        err_nxt      = err_count;
        checks_nxt   = checks;
        mismatch_nxt = 1'b0;
        wrap_nxt     = 1'b0;
        compare      = (state == TRACK);
        miss         = compare && (obs_count != exp);

        if (state != FAIL) begin
            exp_nxt  = pred;
            wrap_nxt = !load && enable && (obs_count == '1);
        end

        if (compare && checks != 16'hFFFF)
            checks_nxt = checks + 16'd1;

        if (miss) begin
            mismatch_nxt = 1'b1;
            if (err_count != 8'hFF)
                err_nxt = err_count + 8'd1;
        end

        case (state)
            SHADOW: begin
                if (check_en)
                    state_nxt = TRACK;
            end
            TRACK: begin
                if (miss && ({1'b0, err_count} + 9'd1) >= 9'(MAX_ERR))
                    state_nxt = FAIL;
                else if (!check_en)
                    state_nxt = SHADOW;
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = SHADOW;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SHADOW;
            exp       <= '0;
            mismatch  <= 1'b0;
            err_count <= '0;
            checks    <= '0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            exp       <= exp_nxt;
            mismatch  <= mismatch_nxt;
            err_count <= err_nxt;
            checks    <= checks_nxt;
            wrap      <= wrap_nxt;
        end
    end

    assign locked = (state == TRACK);
    assign fail   = (state == FAIL);

endmodule
